// File: rtl/sync_stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO with valid/ready ports on both sides.
// Also reports fill level, almost-full/almost-empty flags and a high-water mark.
module sync_stream_fifo #(
  parameter  int BITWIDTH      = 8,
  parameter  int DEPTH         = 4,
  parameter  int AFULL_THRESH  = DEPTH - 1,
  parameter  int AEMPTY_THRESH = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int CW            = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [BITWIDTH-1:0] wr_stream_data,
  input  logic                wr_stream_valid,
  output logic                wr_stream_ready,
  output logic [BITWIDTH-1:0] rd_stream_data,
  output logic                rd_stream_valid,
  input  logic                rd_stream_ready,
  output logic [CW-1:0]       count,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [CW-1:0]       max_count
);

  generate
    if (BITWIDTH < 1) begin : g_bad_width
      $error("BITWIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_T     = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_T     = CW'(AEMPTY_THRESH);

  logic [BITWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_max_count;

  logic                w_full;
  logic                w_empty;
  logic                w_ready;
  logic                w_valid;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_count_nxt;

  // Handshake qualifiers decode from registered occupancy only, so the
  // read-side ready never feeds the write-side ready combinationally.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_ready = ~w_full  & ~flush & ~rst;
  assign w_valid = ~w_empty & ~flush & ~rst;
  assign w_push  = wr_stream_valid & w_ready;
  assign w_pop   = rd_stream_ready & w_valid;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is cleared.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wr_stream_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_max_count <= (w_count_nxt > r_max_count) ? w_count_nxt : r_max_count;
    end
  end

  assign wr_stream_ready = w_ready;
  assign rd_stream_valid = w_valid;
  assign rd_stream_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count           = r_count;
  assign max_count       = r_max_count;
  assign almost_full     = (r_count >= AF_T);
  assign almost_empty    = (r_count <= AE_T);

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Directed and random-backpressure bench for sync_stream_fifo at DEPTH=4, BITWIDTH=8.
// Inputs change 1 time unit after each rising edge; outputs are checked in the same window.
module tb_sync_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] count;
  logic       afull;
  logic       aempty;
  logic [2:0] max_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_stream_fifo #(.BITWIDTH(8), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .wr_stream_data  (wr_data),
    .wr_stream_valid (wr_valid),
    .wr_stream_ready (wr_ready),
    .rd_stream_data  (rd_data),
    .rd_stream_valid (rd_valid),
    .rd_stream_ready (rd_ready),
    .count           (count),
    .almost_full     (afull),
    .almost_empty    (aempty),
    .max_count       (max_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    tick();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rd_valid); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL idle_data got=%h exp=00", rd_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count got=%0d exp=0", count); end
    checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL idle_aempty got=%b exp=1", aempty); end
    checks++; if (afull !== 1'b0) begin errors++; $display("FAIL idle_afull got=%b exp=0", afull); end
    checks++; if (max_count !== 3'd0) begin errors++; $display("FAIL idle_max got=%0d exp=0", max_count); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'h11 * (i + 1)); wr_valid = 1'b1;
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
      checks++; if (afull !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_afull got=%b at count %0d", afull, i + 1); end
      checks++; if (aempty !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_aempty got=%b at count %0d", aempty, i + 1); end
      checks++; if (wr_ready !== (i + 1 < 4)) begin errors++; $display("FAIL fill_ready got=%b at count %0d", wr_ready, i + 1); end
    end
    checks++; if (max_count !== 3'd4) begin errors++; $display("FAIL fill_max got=%0d exp=4", max_count); end
    wr_data = 8'h55; wr_valid = 1'b1;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got=%0d exp=4", count); end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      rd_ready = 1'b1; #1;
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid got=%b exp=1", rd_valid); end
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL drain_data got=%h exp=%h", rd_data, exp); end
      tick();
    end
    rd_ready = 1'b0; #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got=%b exp=0", rd_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained_count got=%0d exp=0", count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL drained_data got=%h exp=00", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_data = 8'(8'hA0 + i); wr_valid = 1'b1;
      tick();
    end
    // Ten pushes on top of two preloaded words wrap both pointers three times.
    rd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_data = 8'(k + 1); wr_valid = 1'b1;
      exp = (k < 2) ? 8'(8'hA0 + k) : 8'(k - 1);
      #1;
      checks++; if (rd_valid !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_bubble valid=%b ready=%b at %0d", rd_valid, wr_ready, k); end
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL b2b_data got=%h exp=%h", rd_data, exp); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", count); end
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = 8'(8'h09 + k);
      #1;
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL b2b_tail got=%h exp=%h", rd_data, exp); end
      tick();
    end
    rd_ready = 1'b0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp;
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'hB0 + i); wr_valid = 1'b1;
      tick();
    end
    wr_data = 8'hB4; wr_valid = 1'b1; rd_ready = 1'b1; #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready got=%b exp=0", wr_ready); end
    checks++; if (rd_data !== 8'hB0) begin errors++; $display("FAIL fullpop_data got=%h exp=b0", rd_data); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    rd_ready = 1'b0; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready2 got=%b exp=1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_push got=%0d exp=4", count); end
    rd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      exp = 8'(8'hB0 + i);
      #1;
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL fullpop_drain got=%h exp=%h", rd_data, exp); end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_flush();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'hC0 + i); wr_valid = 1'b1;
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", count); end
    wr_data = 8'hC3; wr_valid = 1'b1; rd_ready = 1'b1; flush = 1'b1; #1;
    checks++; if (wr_ready !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL flush_hs ready=%b valid=%b exp=0/0", wr_ready, rd_valid); end
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (max_count !== 3'd0) begin errors++; $display("FAIL flush_max got=%0d exp=0", max_count); end
    checks++; if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL flush_idle valid=%b ready=%b exp=0/1", rd_valid, wr_ready); end
    wr_data = 8'hAB; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hAB) begin errors++; $display("FAIL flush_new valid=%b data=%h exp=1/ab", rd_valid, rd_data); end
    checks++; if (max_count !== 3'd1) begin errors++; $display("FAIL flush_newmax got=%0d exp=1", max_count); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_pop got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int peak;
    logic exp_ready, exp_valid;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    peak = 0;
    for (int c = 0; c < 1000; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      rd_ready = ($urandom_range(0, 2) != 0);
      wr_data  = 8'($urandom);
      #1;
      exp_ready = (q.size() < 4);
      exp_valid = (q.size() > 0);
      checks++; if (wr_ready !== exp_ready || rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_hs ready=%b/%b valid=%b/%b cyc %0d", wr_ready, exp_ready, rd_valid, exp_valid, c); end
      if (exp_valid) begin
        checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL rnd_data got=%h exp=%h cyc %0d", rd_data, q[0], c); end
      end
      if (rd_ready && exp_valid) void'(q.pop_front());
      if (wr_valid && exp_ready) q.push_back(wr_data);
      if (q.size() > peak) peak = q.size();
      tick();
      checks++; if (count !== 3'(q.size()) || count > 3'd4) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d cyc %0d", count, q.size(), c); end
      checks++; if (max_count !== 3'(peak)) begin errors++; $display("FAIL rnd_max got=%0d exp=%0d cyc %0d", max_count, peak, c); end
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    rd_ready = 1'b0;
    wr_data = 8'hD0; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL midrst count=%0d valid=%b data=%h exp=0/0/00", count, rd_valid, rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_stream_fifo.md
# sync_stream_fifo

Single-clock, parametrised stream FIFO with first-word-fall-through output and Axis slave/master ports. It buffers `DEPTH` words of `BITWIDTH` bits between a producer and a consumer in the same clock domain. It also reports fill level, almost-full/almost-empty flags and a high-water mark. It is the same-domain companion to the CDC handshake path: it absorbs bursts on either side of a crossing, which the single-word handshake cannot do.

## Interface
Parameters:
- `BITWIDTH`, default 8: data word width; must be ≥1.
- `DEPTH`, default 4: number of storage entries; must be a power of 2 and ≥2.
- `AFULL_THRESH`, default `DEPTH-1`: `almost_full` asserts when `count >= AFULL_THRESH`.
- `AEMPTY_THRESH`, default 1: `almost_empty` asserts when `count <= AEMPTY_THRESH`.

Ports (`CW = $clog2(DEPTH)+1`):
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of contents, counters and high-water mark.
- `wr_stream`  Axis.Slave  `BITWIDTH`  input stream (`data`, `valid`, `ready`, `ok = valid & ready`).
- `rd_stream`  Axis.Master  `BITWIDTH`  output stream (same signals).
- `count`  out  `CW`  current occupancy, 0..`DEPTH`.
- `almost_full`  out  1  `count >= AFULL_THRESH`.
- `almost_empty`  out  1  `count <= AEMPTY_THRESH`.
- `max_count`  out  `CW`  highest `count` reached since the last reset or flush.

## Operation
- Storage: `DEPTH` x `BITWIDTH` register array.
- Pointers: `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, with natural wrap-around at `DEPTH-1` -> 0.
- Occupancy: `count` register, `CW` bits.
- Full/empty:
  - empty = `count == 0`.
  - full = `count == DEPTH`.
  - Both decode from registered state only.
- Write side:
  - `wr_stream.ready = ~full & ~flush`.
  - On `wr_stream.ok`, `mem[wr_ptr] <= data` and `wr_ptr` increments.
- Read side (FWFT):
  - `rd_stream.valid = ~empty & ~flush`.
  - `rd_stream.data = mem[rd_ptr]`, driven 0 when empty.
  - On `rd_stream.ok`, `rd_ptr` increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together, or neither: unchanged.
- Simultaneous push and pop:
  - Allowed whenever not full and not empty; `count` is unchanged and both pointers advance.
  - When full, `ready = 0`, so a same-cycle pop does NOT enable a write. There is no combinational path from `rd_stream.ready` to `wr_stream.ready`.
  - When empty, `valid = 0`, so there is no pop. A write lands and is presented the next cycle; there is no bypass.
- `max_count <= max(max_count, next count)` every cycle.
- Flush:
  - Pointers, `count` and `max_count` go to 0 on the edge.
  - In the flush cycle no handshake occurs on either side.
  - Flush has priority over push and pop. Memory contents are not cleared.
- Reset: same effect as flush. Memory is also cleared to 0.
- No overflow or underflow can occur. The handshakes gate every pointer move.

## Timing
- Reset values:
  - `count = 0`, `max_count = 0`.
  - `wr_stream.ready = 1` (after `rst` deasserts, same cycle `rst` is low).
  - `rd_stream.valid = 0`, `rd_stream.data = 0`.
  - `almost_empty = 1`.
  - `almost_full = 0` (given `AFULL_THRESH ≥ 1`).
- During `rst` high:
  - `ready = 0` and `valid = 0`.
  - Mid-operation reset discards all stored words on that edge.
- Write-to-read latency: a word accepted on edge N is visible on `rd_stream` after edge N, i.e. it can be popped at edge N+1.
- `count`, `almost_full`, `almost_empty` and `max_count` reflect state after each edge. Flags are combinational decodes of the `count` register.
- Throughput: 1 word/cycle sustained in both directions when `0 < count < DEPTH`.
- Ordering: strict FIFO, across pointer wrap-around.

## Test plan
- Reset/idle: assert `rst` 2 cycles, then release -> `ready=1`, `valid=0`, `count=0`, `almost_empty=1`, `max_count=0`.
- Fill to full, then drain (`DEPTH=4`, `BITWIDTH=8`):
  - Push 0x11, 0x22, 0x33, 0x44 back-to-back with `rd ready=0` -> `count` goes 1,2,3,4.
  - `almost_full` rises at `count=3`; `ready=0` at `count=4`; `max_count=4`.
  - 5th push 0x55 held with `valid=1` is not accepted.
  - Drain -> outputs 0x11..0x44 in order, then `valid=0`.
- Simultaneous push/pop with wrap:
  - Preload 2 words, then stream 0x01..0x0A with `rd ready=1` continuously.
  - Required: `count` stays 2, pointers wrap at least twice, output order exact, no bubbles.
- Full plus pop:
  - At `count=4`, assert `rd ready=1` and `wr valid=1` in the same cycle.
  - Required: one pop, no push, `count=3`; the push is accepted on the next cycle.
- Flush mid-stream:
  - At `count=3` with both handshakes active, pulse `flush` 1 cycle.
  - Required: no transfer in that cycle; next cycle `count=0`, `max_count=0`, `valid=0`, `ready=1`; a new word 0xAB then emerges first.
- Random backpressure: 1000 cycles of random `valid`/`ready` -> scoreboard matches exactly, `count` never exceeds 4, `max_count` equals the peak observed occupancy.
